// File: rtl/conv2d_layer_sequencer.sv
// conv2d_layer_sequencer: feeds one zero-padded frame from NUM_CH lock-step FIFOs to the conv2D array and counts its outputs
// ports: clk/rst (async active-high); start_i begins a frame; fifo_empty_i/fifo_rdreq_o FIFO handshake;
//        pad_sel_o/pad_data_o/conv_valid_o drive the conv2D inputs; fm_valid_i output pulses from the adder;
//        busy_o while feeding/draining, done_o one-cycle frame-complete pulse, err_o sticky protocol error
module conv2d_layer_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int NUM_CH     = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [NUM_CH-1:0]     fifo_empty_i,
  output logic                  fifo_rdreq_o,
  output logic                  pad_sel_o,
  output logic [DATA_WIDTH-1:0] pad_data_o,
  output logic                  conv_valid_o,
  input  logic                  fm_valid_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] NOUT = CNT_W'(WIDTH * WIDTH);
  state_t           state_q;
  logic [CNT_W-1:0] row_q, col_q, ocnt_q;
  logic             err_q;
  logic             feed, border, all_rdy, adv, last_beat, fm_cnt, fm_last, fm_err;
  always_comb begin
    feed      = state_q == FEED;
    border    = row_q == '0 || row_q == LAST || col_q == '0 || col_q == LAST;
    all_rdy   = ~|fifo_empty_i;
    adv       = feed && (border || all_rdy);
    last_beat = adv && row_q == LAST && col_q == LAST;
    fm_cnt    = fm_valid_i && (feed || state_q == DRAIN) && ocnt_q != NOUT;
    fm_last   = fm_cnt && ocnt_q == NOUT - 1'b1;
    // anything not countable is a protocol error: IDLE, DONE or beyond the frame
    fm_err    = fm_valid_i && !fm_cnt;
  end
  assign conv_valid_o = adv;
  assign pad_sel_o    = adv && border;
  assign fifo_rdreq_o = adv && !border;
  assign pad_data_o   = '0;
  assign busy_o       = feed || state_q == DRAIN;
  assign done_o       = state_q == DONE;
  assign err_o        = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ocnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (fm_cnt) ocnt_q <= ocnt_q + 1'b1;
      if (fm_err) err_q <= 1'b1;
      if (adv) begin
        col_q <= (col_q == LAST) ? '0 : col_q + 1'b1;
        if (col_q == LAST) row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
      end
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= FEED;
          row_q   <= '0;
          col_q   <= '0;
          ocnt_q  <= '0;
          err_q   <= 1'b0;
        end
        // outputs that all arrive before the last feed beat are held until that beat
        FEED:    if (last_beat) state_q <= (fm_last || ocnt_q == NOUT) ? DONE : DRAIN;
        DRAIN:   if (fm_last) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
